// File: rtl/mem_issue_ctrl_if.sv
// Cache-side request/response bus of the memory-op sequencer.
// The master modport is the sequencer and the slave modport is the data cache.
interface mem_issue_ctrl_if #(
   parameter int ADDR_W = 32
);
   logic              dreq_valid;
   logic              dreq_write;
   logic [1:0]        dreq_size;
   logic [ADDR_W-1:0] dreq_addr;
   logic [ADDR_W-1:0] dreq_wdata;
   logic [3:0]        dreq_strb;
   logic              daddr_ok;
   logic              ddata_ok;
   logic [ADDR_W-1:0] drdata;

   modport master (
      output dreq_valid, dreq_write, dreq_size, dreq_addr, dreq_wdata, dreq_strb,
      input  daddr_ok, ddata_ok, drdata
   );

   modport slave (
      input  dreq_valid, dreq_write, dreq_size, dreq_addr, dreq_wdata, dreq_strb,
      output daddr_ok, ddata_ok, drdata
   );
endinterface

// File: rtl/mem_issue_ctrl.sv
// Single-outstanding load/store sequencer between the issue stage and the data cache.
// Holds one op, runs the addr/data handshake and returns a one-cycle completion pulse.
module mem_issue_ctrl #(
   parameter int PREG_W = 6,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              mem_issued,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [ADDR_W-1:0] req_wdata,
   input  logic [3:0]        req_strb,
   input  logic [PREG_W-1:0] req_preg,
   output logic              wait_mem,
   mem_issue_ctrl_if.master  dbus,
   output logic              resp_valid,
   output logic              resp_write,
   output logic [PREG_W-1:0] resp_preg,
   output logic [ADDR_W-1:0] resp_data
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t            state, state_nxt;
   logic              capture, data_done, dreq_valid;
   logic              kill;
   logic              op_write;
   logic [1:0]        op_size;
   logic [ADDR_W-1:0] op_addr;
   logic [ADDR_W-1:0] op_wdata;
   logic [3:0]        op_strb;
   logic [PREG_W-1:0] op_preg;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         kill      <= 1'b0;
         op_write  <= 1'b0;
         op_size   <= '0;
         op_addr   <= '0;
         op_wdata  <= '0;
         op_strb   <= '0;
         op_preg   <= '0;
         resp_data <= '0;
      end else begin
         state <= state_nxt;
         if (capture) begin
            op_write <= req_write;
            op_size  <= req_size;
            op_addr  <= req_addr;
            op_wdata <= req_wdata;
            op_strb  <= req_strb;
            op_preg  <= req_preg;
            kill     <= 1'b0;
         end else if (flush && state != IDLE) begin
            // A flushed op still finishes its cache handshake; only the result is dropped.
            kill <= 1'b1;
         end
         if (data_done) begin
            resp_data <= op_write ? '0 : dbus.drdata;
         end
      end
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_nxt  = state;
      capture    = 1'b0;
      data_done  = 1'b0;
      dreq_valid = 1'b0;
      resp_valid = 1'b0;
      wait_mem   = (state != IDLE);
      unique case (state)
         IDLE: begin
            if (mem_issued && !flush) begin
               capture   = 1'b1;
               state_nxt = REQ;
            end
         end
         REQ: begin
            dreq_valid = 1'b1;
            if (dbus.daddr_ok) begin
               data_done = dbus.ddata_ok;
               state_nxt = dbus.ddata_ok ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (dbus.ddata_ok) begin
               data_done = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            resp_valid = !kill && !flush;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign dbus.dreq_valid = dreq_valid;
   assign dbus.dreq_write = op_write;
   assign dbus.dreq_size  = op_size;
   assign dbus.dreq_addr  = op_addr;
   assign dbus.dreq_wdata = op_wdata;
   assign dbus.dreq_strb  = op_strb;
   assign resp_write      = op_write;
   assign resp_preg       = op_preg;

   // Issue must honour wait_mem; a second op while busy is ignored.
   no_issue_while_busy: assert property (@(posedge clk) disable iff (reset) !(mem_issued && wait_mem));
endmodule
